alu_operand_collector: RTL and testbench
========================================

Name: alu_operand_collector

Overview:
- Upstream stage of the ALU core.
- Accepts operand/command beats whose operands may arrive split across cycles (inp_valid = 01 / 10 / 11).
- Assembles a complete operation and issues it to the ALU core through a valid/ready handshake.
- Flags missing-operand timeouts and empty requests as errors.

Parameters:
- DATA_WIDTH, 8: operand width of opa/opb.
- CMD_WIDTH, 4: command field width.
- TIMEOUT_CYCLES, 16: enabled cycles to wait for a missing second operand; legal range 1..255.
- TWO_OP_MASK_ARITH, 16'h070F: bit n set means cmd n needs both operands when mode=1.
- TWO_OP_MASK_LOGIC, 16'h303F: bit n set means cmd n needs both operands when mode=0.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- ce  in  1  clock enable; when 0, FSM, timer and input latches hold.
- mode  in  1  1 = arithmetic, 0 = logical.
- cin  in  1  carry-in.
- cmd  in  CMD_WIDTH  command.
- opa  in  DATA_WIDTH  operand A.
- opb  in  DATA_WIDTH  operand B.
- inp_valid  in  2  bit0 = opa valid, bit1 = opb valid.
- in_ready  out  1  collector can accept a beat.
- o_valid  out  1  assembled operation available.
- o_ready  in  1  ALU core accepts the operation.
- o_mode, o_cin, o_cmd  out  1/1/CMD_WIDTH  latched control.
- o_opa, o_opb  out  DATA_WIDTH  latched operands; 0 if never received.
- o_inp_valid  out  2  operands actually collected.
- o_err  out  1  timeout or empty request.

Behaviour:
- A beat is taken when ce=1 and in_ready=1; in_ready = ce && state != ISSUE.
- Reset (asynchronous, active-high):
  - State returns to IDLE; timer = 0.
  - All o_* outputs = 0; in_ready follows ce.
  - Reset mid-WAIT or mid-ISSUE discards the pending operation; nothing is issued.
- need_both = mode ? TWO_OP_MASK_ARITH[cmd] : TWO_OP_MASK_LOGIC[cmd]. Bits above CMD_WIDTH range read as 0.
- IDLE, on an accepted beat:
  - Latch mode, cin, cmd; latch opa if inp_valid[0], opb if inp_valid[1]; clear the other operand to 0.
  - inp_valid=00 → ISSUE with o_err=1, o_inp_valid=00.
  - need_both=0 and inp_valid≠00 → ISSUE, o_err=0.
  - need_both=1 and inp_valid=11 → ISSUE, o_err=0.
  - need_both=1 and inp_valid=01 or 10 → WAIT, timer=0.
- WAIT (each cycle with ce=1):
  - mode/cmd/cin of new beats are ignored.
  - If the missing operand's valid bit is set, latch only that operand → ISSUE, o_inp_valid=11, o_err=0.
  - Re-supplying the already-held operand does not overwrite it.
  - Otherwise timer++. When timer reaches TIMEOUT_CYCLES-1 without arrival → ISSUE with o_err=1, partial o_inp_valid kept.
  - An arrival on the same cycle as expiry wins: no error.
- ISSUE:
  - o_valid=1, all o_* outputs stable until o_ready=1.
  - o_ready=1 in ISSUE → IDLE next cycle; o_valid drops.
  - Back-to-back operations: minimum 2 cycles per operation (accept, then issue), independent of ce.
  - ce is ignored in ISSUE; the handshake completes even when ce=0.
- Latency: accept of the completing beat → o_valid=1 on the next rising clk edge.
- ce=0 in IDLE/WAIT freezes state and timer; the timeout counts enabled cycles only.

Optional Feature:
- Macro ALU_COLLECT_STATS_EN.
- Defined: adds output ports stat_issued [15:0] and stat_timeouts [15:0].
  - stat_issued increments on every o_valid && o_ready.
  - stat_timeouts increments on handshakes whose error came from a timeout (not from empty requests).
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Two-operand op in one beat: mode=1, cmd=0, opa=8'h12, opb=8'h34, inp_valid=11, o_ready=1 → next cycle o_valid=1, o_opa=12, o_opb=34, o_inp_valid=11, o_err=0; o_valid drops the cycle after.
- Split arrival: mode=1, cmd=0, opa=8'hA5 with inp_valid=01; 5 cycles later opb=8'h5A with inp_valid=10 and cmd=4'h9 → issue with o_cmd=0, o_opa=A5, o_opb=5A, o_err=0.
- Timeout: mode=0, cmd=1, inp_valid=10, opb=8'hFF, then inp_valid=00 → o_valid rises exactly TIMEOUT_CYCLES (16) enabled cycles after acceptance, with o_err=1, o_inp_valid=10, o_opa=0.
- ce gating: as in the timeout scenario, but ce=0 for 10 of the wait cycles → timeout delayed by exactly 10 cycles.
- Backpressure plus reset: issue with o_ready=0 for 4 cycles → outputs stable and in_ready=0; assert rst mid-hold → o_valid=0 immediately, IDLE; no issue after rst drops.
- Empty request: ce=1, inp_valid=00, cmd=3 → next cycle o_valid=1, o_err=1, o_inp_valid=00; with ALU_COLLECT_STATS_EN, stat_issued=1 and stat_timeouts=0.

Source files
------------

// File: rtl/alu_operand_collector_if.sv
// alu_operand_collector_if: operand beat input and assembled-operation issue bundle
interface alu_operand_collector_if #(
    parameter int DATA_WIDTH = 8,
    parameter int CMD_WIDTH  = 4
);
    logic                  mode;
    logic                  cin;
    logic [CMD_WIDTH-1:0]  cmd;
    logic [DATA_WIDTH-1:0] opa;
    logic [DATA_WIDTH-1:0] opb;
    logic [1:0]            inp_valid;
    logic                  in_ready;
    logic                  o_valid;
    logic                  o_ready;
    logic                  o_mode;
    logic                  o_cin;
    logic [CMD_WIDTH-1:0]  o_cmd;
    logic [DATA_WIDTH-1:0] o_opa;
    logic [DATA_WIDTH-1:0] o_opb;
    logic [1:0]            o_inp_valid;
    logic                  o_err;
    modport master (
        output mode, cin, cmd, opa, opb, inp_valid, o_ready,
        input  in_ready, o_valid, o_mode, o_cin, o_cmd, o_opa, o_opb, o_inp_valid, o_err
    );
    modport slave (
        input  mode, cin, cmd, opa, opb, inp_valid, o_ready,
        output in_ready, o_valid, o_mode, o_cin, o_cmd, o_opa, o_opb, o_inp_valid, o_err
    );
endinterface

// File: rtl/alu_operand_collector.sv
// alu_operand_collector: assembles split operand beats into one ALU operation (ALU_COLLECT_STATS_EN adds issue/timeout counters)
module alu_operand_collector #(
    parameter int               DATA_WIDTH        = 8,
    parameter int               CMD_WIDTH         = 4,
    parameter int               TIMEOUT_CYCLES    = 16,
    parameter logic [15:0]      TWO_OP_MASK_ARITH = 16'h070F,
    parameter logic [15:0]      TWO_OP_MASK_LOGIC = 16'h303F
) (
    input logic clk,
    input logic rst,
    input logic ce,
    alu_operand_collector_if.slave bus
`ifdef ALU_COLLECT_STATS_EN
    ,
    output logic [15:0] stat_issued,
    output logic [15:0] stat_timeouts
`endif
);
    typedef enum logic [1:0] {IDLE, WAIT, ISSUE} state_t;
    state_t      state;
    logic [7:0]  timer;
    logic        timed_out;
    logic [15:0] mask;
    logic        need_both;
    logic [1:0]  arriving;
    assign bus.in_ready = ce && state != ISSUE;
    assign mask = bus.mode ? TWO_OP_MASK_ARITH : TWO_OP_MASK_LOGIC;
    // commands beyond the 16-entry masks never need a second operand
    assign need_both = mask[4'(bus.cmd)] && (bus.cmd >> 4) == '0;
    assign arriving = bus.inp_valid & ~bus.o_inp_valid;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            timer           <= '0;
            timed_out       <= 1'b0;
            bus.o_valid     <= 1'b0;
            bus.o_mode      <= 1'b0;
            bus.o_cin       <= 1'b0;
            bus.o_cmd       <= '0;
            bus.o_opa       <= '0;
            bus.o_opb       <= '0;
            bus.o_inp_valid <= '0;
            bus.o_err       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (ce) begin
                    bus.o_mode      <= bus.mode;
                    bus.o_cin       <= bus.cin;
                    bus.o_cmd       <= bus.cmd;
                    bus.o_opa       <= bus.inp_valid[0] ? bus.opa : '0;
                    bus.o_opb       <= bus.inp_valid[1] ? bus.opb : '0;
                    bus.o_inp_valid <= bus.inp_valid;
                    bus.o_err       <= bus.inp_valid == 2'b00;
                    timed_out       <= 1'b0;
                    timer           <= '0;
                    if (need_both && ^bus.inp_valid) begin
                        state <= WAIT;
                    end else begin
                        state       <= ISSUE;
                        bus.o_valid <= 1'b1;
                    end
                end
                // an arrival on the expiry cycle takes priority over the timeout
                WAIT: if (ce) begin
                    if (|arriving) begin
                        if (arriving[0]) bus.o_opa <= bus.opa;
                        if (arriving[1]) bus.o_opb <= bus.opb;
                        bus.o_inp_valid <= 2'b11;
                        state           <= ISSUE;
                        bus.o_valid     <= 1'b1;
                    end else if (timer == 8'(TIMEOUT_CYCLES - 1)) begin
                        bus.o_err   <= 1'b1;
                        timed_out   <= 1'b1;
                        state       <= ISSUE;
                        bus.o_valid <= 1'b1;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                ISSUE: if (bus.o_ready) begin
                    state       <= IDLE;
                    bus.o_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef ALU_COLLECT_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_issued   <= '0;
            stat_timeouts <= '0;
        end else if (bus.o_valid && bus.o_ready) begin
            stat_issued   <= stat_issued + 16'(stat_issued != 16'hFFFF);
            stat_timeouts <= stat_timeouts + 16'(timed_out && stat_timeouts != 16'hFFFF);
        end
    end
`endif
endmodule

// File: tb/tb_alu_operand_collector.sv
// tb_alu_operand_collector: directed stimulus with a scoreboard of expected issued operations
module tb_alu_operand_collector;
    typedef struct packed {
        logic       mode;
        logic       cin;
        logic [3:0] cmd;
        logic [7:0] opa;
        logic [7:0] opb;
        logic [1:0] iv;
        logic       err;
    } op_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ce  = 1'b1;
    int   errors = 0;
    int   checks = 0;
    op_t  sb[$];
    op_t  got;
    op_t  exp_op;
    alu_operand_collector_if #(.DATA_WIDTH(8), .CMD_WIDTH(4)) bus ();
`ifdef ALU_COLLECT_STATS_EN
    logic [15:0] stat_issued;
    logic [15:0] stat_timeouts;
`endif
    alu_operand_collector #(.DATA_WIDTH(8), .CMD_WIDTH(4), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk),
        .rst(rst),
        .ce(ce),
        .bus(bus.slave)
`ifdef ALU_COLLECT_STATS_EN
        ,
        .stat_issued(stat_issued),
        .stat_timeouts(stat_timeouts)
`endif
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        checks++;
        assert (got_v === exp_v) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got_v, exp_v);
        end
    endtask
    task automatic beat(input logic m, input logic c, input logic [3:0] cm,
                        input logic [7:0] a, input logic [7:0] b, input logic [1:0] iv);
        bus.mode = m; bus.cin = c; bus.cmd = cm; bus.opa = a; bus.opb = b; bus.inp_valid = iv;
    endtask
    task automatic handshake();
        ce = 1'b0;
        bus.inp_valid = 2'b00;
        bus.o_ready = 1'b1;
        tick();
        bus.o_ready = 1'b0;
        chk("valid_drop", 32'(bus.o_valid), 0);
    endtask
    always @(negedge clk) begin
        if (!rst && bus.o_valid && bus.o_ready) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL sb_underflow got=issue exp=none");
            end
            if (sb.size() != 0) begin
                exp_op = sb.pop_front();
                got = '{bus.o_mode, bus.o_cin, bus.o_cmd, bus.o_opa, bus.o_opb, bus.o_inp_valid, bus.o_err};
                assert (got === exp_op) else begin
                    errors++;
                    $error("FAIL issue got=%h exp=%h", got, exp_op);
                end
            end
        end
    end
    initial begin
        #100000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end
    initial begin
        beat(0, 0, 0, 0, 0, 2'b00);
        bus.o_ready = 1'b0;
        tick();
        chk("rst_valid", 32'(bus.o_valid), 0);
        chk("rst_err", 32'(bus.o_err), 0);
        chk("rst_opa", 32'(bus.o_opa), 0);
        chk("rst_iv", 32'(bus.o_inp_valid), 0);
        chk("rst_in_ready_ce1", 32'(bus.in_ready), 1);
        ce = 1'b0;
        #1;
        chk("rst_in_ready_ce0", 32'(bus.in_ready), 0);
        tick();
        rst = 1'b0;
        tick();
        chk("idle_ce0_valid", 32'(bus.o_valid), 0);
        // two operands in a single beat
        ce = 1'b1;
        beat(1, 0, 4'h0, 8'h12, 8'h34, 2'b11);
        sb.push_back('{1'b1, 1'b0, 4'h0, 8'h12, 8'h34, 2'b11, 1'b0});
        tick();
        ce = 1'b0;
        chk("one_beat_valid", 32'(bus.o_valid), 1);
        chk("one_beat_in_ready", 32'(bus.in_ready), 0);
        chk("one_beat_opa", 32'(bus.o_opa), 32'h12);
        handshake();
        // split arrival with a re-supplied opa that must not overwrite
        ce = 1'b1;
        beat(1, 0, 4'h0, 8'hA5, 8'h00, 2'b01);
        sb.push_back('{1'b1, 1'b0, 4'h0, 8'hA5, 8'h5A, 2'b11, 1'b0});
        tick();
        for (int i = 1; i <= 4; i++) begin
            beat(0, 1, 4'h7, 8'hFF, 8'h00, i == 2 ? 2'b01 : 2'b00);
            tick();
        end
        chk("split_wait_valid", 32'(bus.o_valid), 0);
        beat(0, 1, 4'h9, 8'hFF, 8'h5A, 2'b10);
        tick();
        chk("split_valid", 32'(bus.o_valid), 1);
        chk("split_cmd", 32'(bus.o_cmd), 0);
        handshake();
        // timeout after 16 enabled cycles
        ce = 1'b1;
        beat(0, 1, 4'h1, 8'h77, 8'hFF, 2'b10);
        sb.push_back('{1'b0, 1'b1, 4'h1, 8'h00, 8'hFF, 2'b10, 1'b1});
        tick();
        bus.inp_valid = 2'b00;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i >= 15) chk($sformatf("to_valid_%0d", i), 32'(bus.o_valid), 32'(i == 16));
        end
        chk("to_err", 32'(bus.o_err), 1);
        chk("to_iv", 32'(bus.o_inp_valid), 2'b10);
        chk("to_opa", 32'(bus.o_opa), 0);
        handshake();
        // same timeout with 10 disabled cycles inside the wait
        ce = 1'b1;
        beat(0, 1, 4'h1, 8'h77, 8'hFF, 2'b10);
        sb.push_back('{1'b0, 1'b1, 4'h1, 8'h00, 8'hFF, 2'b10, 1'b1});
        tick();
        bus.inp_valid = 2'b00;
        for (int i = 1; i <= 26; i++) begin
            ce = (i > 5 && i <= 15) ? 1'b0 : 1'b1;
            if (i == 6) begin
                #1;
                chk("ce0_in_ready", 32'(bus.in_ready), 0);
            end
            tick();
            if (i == 16 || i >= 25) chk($sformatf("ce_to_valid_%0d", i), 32'(bus.o_valid), 32'(i == 26));
        end
        chk("ce_to_err", 32'(bus.o_err), 1);
        handshake();
        // arrival on the expiry cycle wins
        ce = 1'b1;
        beat(1, 0, 4'h0, 8'h11, 8'h00, 2'b01);
        sb.push_back('{1'b1, 1'b0, 4'h0, 8'h11, 8'h22, 2'b11, 1'b0});
        tick();
        bus.inp_valid = 2'b00;
        for (int i = 1; i <= 15; i++) tick();
        chk("edge_wait_valid", 32'(bus.o_valid), 0);
        bus.opb = 8'h22;
        bus.inp_valid = 2'b10;
        tick();
        chk("edge_valid", 32'(bus.o_valid), 1);
        chk("edge_err", 32'(bus.o_err), 0);
        handshake();
        // single operand command issues without waiting
        ce = 1'b1;
        beat(0, 0, 4'h6, 8'h66, 8'h99, 2'b01);
        sb.push_back('{1'b0, 1'b0, 4'h6, 8'h66, 8'h00, 2'b01, 1'b0});
        tick();
        chk("single_valid", 32'(bus.o_valid), 1);
        handshake();
`ifdef ALU_COLLECT_STATS_EN
        chk("stat_issued_6", 32'(stat_issued), 6);
        chk("stat_timeouts_2", 32'(stat_timeouts), 2);
`endif
        // backpressure then reset mid-hold
        ce = 1'b1;
        beat(1, 1, 4'h2, 8'h3C, 8'hC3, 2'b11);
        tick();
        beat(0, 0, 4'h5, 8'h00, 8'h00, 2'b11);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("bp_valid_%0d", i), 32'(bus.o_valid), 1);
            chk($sformatf("bp_opa_%0d", i), 32'(bus.o_opa), 32'h3C);
            chk($sformatf("bp_in_ready_%0d", i), 32'(bus.in_ready), 0);
        end
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(bus.o_valid), 0);
        chk("async_rst_opa", 32'(bus.o_opa), 0);
        tick();
        rst = 1'b0;
        ce = 1'b0;
        bus.inp_valid = 2'b00;
        bus.o_ready = 1'b1;
        for (int i = 1; i <= 3; i++) tick();
        chk("post_rst_valid", 32'(bus.o_valid), 0);
        bus.o_ready = 1'b0;
`ifdef ALU_COLLECT_STATS_EN
        chk("stat_rst", 32'({stat_issued, stat_timeouts}), 0);
`endif
        // empty request
        ce = 1'b1;
        beat(0, 0, 4'h3, 8'h00, 8'h00, 2'b00);
        sb.push_back('{1'b0, 1'b0, 4'h3, 8'h00, 8'h00, 2'b00, 1'b1});
        tick();
        ce = 1'b0;
        chk("empty_valid", 32'(bus.o_valid), 1);
        chk("empty_err", 32'(bus.o_err), 1);
        chk("empty_iv", 32'(bus.o_inp_valid), 0);
        handshake();
`ifdef ALU_COLLECT_STATS_EN
        chk("stat_issued_1", 32'(stat_issued), 1);
        chk("stat_timeouts_0", 32'(stat_timeouts), 0);
`endif
        chk("sb_empty", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
